// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: instruction memory port, branch redirect and decode handshake.
interface instr_fetch_queue_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            branch_valid;
  logic [XLEN-1:0] branch_target;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus8_out;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  branch_valid, branch_target,
    output instr_valid,
    input  instr_ready,
    output instr_out, pc_out, pc_plus8_out
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output branch_valid, branch_target,
    input  instr_valid,
    output instr_ready,
    input  instr_out, pc_out, pc_plus8_out
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC, instruction memory requests and a prefetch queue feeding decode.
// Redirects flush both queued entries and the in-flight fetch.
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = PW + 1;

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;

  logic req_c;
  logic push_c;
  logic pop_c;
  logic unused_bt_c;

  // Credit check counts the in-flight word so a return always has a free slot.
  always_comb begin
    req_c  = 1'b0;
    push_c = 1'b0;
    pop_c  = 1'b0;
    req_c  = !rst && !bus.branch_valid &&
             ((count + CW'(inflight)) < CW'(DEPTH));
    push_c = inflight && !bus.branch_valid;
    pop_c  = (count != CW'(0)) && bus.instr_ready;
  end

  assign unused_bt_c = ^bus.branch_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (bus.branch_valid) begin
      fpc      <= {bus.branch_target[XLEN-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      if (push_c) begin
        q_pc[tail]    <= inflight_pc;
        q_instr[tail] <= bus.imem_rdata;
        tail          <= tail + PW'(1);
      end
      if (pop_c) begin
        head <= head + PW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      inflight <= req_c;
      if (req_c) begin
        inflight_pc <= fpc;
        fpc         <= fpc + XLEN'(4);
      end
    end
  end

  assign bus.imem_req     = req_c;
  assign bus.imem_addr    = fpc;
  assign bus.instr_valid  = (count != CW'(0));
  assign bus.instr_out    = q_instr[head];
  assign bus.pc_out       = q_pc[head];
  assign bus.pc_plus8_out = q_pc[head] + XLEN'(8);
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fetch-order scoreboard.
module tb_instr_fetch_queue;
  localparam logic [31:0] K = 32'hE3A0_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue_if ifa ();
  instr_fetch_queue_if ifb ();

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(ifa.master)
  );
  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .bus(ifb.master)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous instruction memories.
  always @(posedge clk) begin
    if (ifa.imem_req) ifa.imem_rdata <= ifa.imem_addr ^ K;
    if (ifb.imem_req) ifb.imem_rdata <= ifb.imem_addr ^ K;
  end

  logic [31:0] sbq [$];
  logic [31:0] exp_fpc;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
  int          nreq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, score requests and pops, then advance past the edge.
  task automatic cyc(input logic rdy, input logic bv, input logic [31:0] bt);
    logic [31:0] e;
    ifa.instr_ready   = rdy;
    ifa.branch_valid  = bv;
    ifa.branch_target = bt;
    #1;
    s_req   = ifa.imem_req;
    s_addr  = ifa.imem_addr;
    s_valid = ifa.instr_valid;
    s_pc    = ifa.pc_out;
    if (s_req) begin
      chk("imem_addr", s_addr, exp_fpc);
      sbq.push_back(s_addr);
      exp_fpc = exp_fpc + 32'd4;
    end
    if (s_valid && rdy) begin
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("pop_pc", ifa.pc_out, e);
        chk("pop_instr", ifa.instr_out, e ^ K);
        chk("pop_pc8", ifa.pc_plus8_out, e + 32'd8);
      end
    end
    if (bv) begin
      sbq.delete();
      exp_fpc = {bt[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.instr_ready   = 1'b0;
    ifa.branch_valid  = 1'b0;
    ifa.branch_target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    exp_fpc = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    ifa.instr_ready   = 1'b0;
    ifa.branch_valid  = 1'b0;
    ifa.branch_target = '0;
    ifb.instr_ready   = 1'b1;
    ifb.branch_valid  = 1'b0;
    ifb.branch_target = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset values.
    chk("rst_valid", 32'(ifa.instr_valid), 32'd0);
    chk("rst_req", 32'(ifa.imem_req), 32'd0);
    chk("rst_addr", ifa.imem_addr, 32'h0);
    chk("rst_instr", ifa.instr_out, 32'h0);
    chk("rst_pc", ifa.pc_out, 32'h0);
    chk("rst_pc8", ifa.pc_plus8_out, 32'h8);
    chk("rst_addr_wrap", ifb.imem_addr, 32'hFFFF_FFF8);

    // Streaming from reset, with the wrapping instance alongside.
    rst = 1'b0;
    sbq.delete();
    exp_fpc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      chk("stream_valid", 32'(ifa.instr_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        chk("first_pc", ifa.pc_out, 32'h0);
        chk("first_pc8", ifa.pc_plus8_out, 32'h8);
      end
      if (k >= 2 && k <= 5) chk("wrap_pc", ifb.pc_out, wrap_exp[k-2]);
      cyc(1'b1, 1'b0, 32'h0);
      chk("stream_req", 32'(s_req), 32'd1);
    end

    // Backpressure from reset: four entries, then requests stop.
    do_reset();
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      nreq += int'(s_req);
    end
    chk("bp_req_count", 32'(nreq), 32'd4);
    chk("bp_req_low", 32'(s_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("bp_first_pop_valid", 32'(s_valid), 32'd1);
    chk("bp_first_pop_req", 32'(s_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("bp_resume_req", 32'(s_req), 32'd1);
    chk("bp_resume_addr", s_addr, 32'h10);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("bp_drain_valid", 32'(s_valid), 32'd1);
    end

    // Branch while streaming.
    do_reset();
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0103);
    chk("br_req", 32'(s_req), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("br_t1_valid", 32'(s_valid), 32'd0);
    chk("br_t1_addr", s_addr, 32'h100);
    chk("br_t1_req", 32'(s_req), 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("br_t2_valid", 32'(s_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("br_t3_valid", 32'(s_valid), 32'd1);
    chk("br_t3_pc", s_pc, 32'h100);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 32'h0);

    // Branch together with a pop of a full queue.
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0040);
    chk("brfull_pop_valid", 32'(s_valid), 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("brfull_t1_valid", 32'(s_valid), 32'd0);
    chk("brfull_t1_addr", s_addr, 32'h40);
    cyc(1'b1, 1'b0, 32'h0);
    chk("brfull_t2_valid", 32'(s_valid), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("brfull_t3_pc", s_pc, 32'h40);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 32'h0);

    // Mid-stream reset with three entries queued and one in flight.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0);
    chk("mid_pre_valid", 32'(ifa.instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ifa.instr_valid), 32'd0);
    chk("mid_rst_addr", ifa.imem_addr, 32'h0);
    chk("mid_rst_req", 32'(ifa.imem_req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    exp_fpc = 32'h0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("mid_restart_valid", 32'(s_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) chk("mid_restart_pc", s_pc, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
